// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with RV32I base ops and an optional iterative
// RV32M unit (shift-add multiplier, restoring divider).
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high
//   in_valid   in   operation offered
//   in_ready   out  block can accept (IDLE and not in reset)
//   op         in   [4]=M select; [3:0] base code, or [2:0]=funct3 for M ops
//   src_a      in   operand A (XLEN)
//   src_b      in   operand B (XLEN)
//   out_valid  out  result/zero/err valid (DONE)
//   out_ready  in   consumer takes the result
//   result     out  registered result (XLEN)
//   zero       out  result == 0
//   err        out  illegal op code
module alu_seq #(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            err
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_n;

  function automatic logic base_legal(input logic [3:0] code);
    case (code)
      4'b0000, 4'b1000, 4'b0001, 4'b0101, 4'b1101,
      4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b0111: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] base_alu(input logic [3:0] code,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic        [SHW-1:0]  sh;
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic signed [XLEN-1:0] sra_s;
    sh    = b[SHW-1:0];
    a_s   = a;
    b_s   = b;
    sra_s = a_s >>> sh;
    case (code)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << sh;
      4'b0101: return a >> sh;
      4'b1101: return sra_s;
      4'b0010: return {{(XLEN-1){1'b0}}, (a_s < b_s)};
      4'b0011: return {{(XLEN-1){1'b0}}, (a < b)};
      4'b0100: return a ^ b;
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return '0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] fix_sign(input logic neg, input logic [XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] fix_sign_wide(input logic neg,
                                                      input logic [2*XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

  // Accept-stage decode (combinational on the offered operation)
  logic [2:0]      fn;
  logic            is_div;
  logic            sgn_a;
  logic            sgn_b;
  logic            neg_a;
  logic            neg_b;
  logic            div0;
  logic            ovf;
  logic            go_calc;
  logic            accept;
  logic [XLEN-1:0] imm_res;
  logic            imm_err;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;

  assign fn     = op[2:0];
  assign is_div = fn[2];
  // Operand signedness: MULH s*s, MULHSU s*u, DIV/REM s/s; all others unsigned.
  assign sgn_a  = (fn == 3'b001) || (fn == 3'b010) || (fn == 3'b100) || (fn == 3'b110);
  assign sgn_b  = (fn == 3'b001) || (fn == 3'b100) || (fn == 3'b110);
  assign neg_a  = sgn_a && src_a[XLEN-1];
  assign neg_b  = sgn_b && src_b[XLEN-1];
  assign mag_a  = fix_sign(neg_a, src_a);
  assign mag_b  = fix_sign(neg_b, src_b);
  assign div0   = is_div && (src_b == '0);
  assign ovf    = is_div && !fn[0] && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
  assign go_calc = op[4] && EN_M && !div0 && !ovf;
  assign accept  = (state == IDLE) && in_valid;

  always_comb begin
    imm_res = '0;
    imm_err = 1'b0;
    if (!op[4]) begin
      imm_err = !base_legal(op[3:0]);
      imm_res = imm_err ? '0 : base_alu(op[3:0], src_a, src_b);
    end else if (!EN_M) begin
      imm_err = 1'b1;
    end else if (div0) begin
      imm_res = fn[1] ? src_a : '1;
    end else if (ovf) begin
      imm_res = fn[1] ? '0 : src_a;
    end
  end

  // Iterative stage: registered operands and accumulator
  logic [2:0]      fn_p0;
  logic            neg_q_p0;
  logic            neg_r_p0;
  logic [XLEN-1:0] mag_b_p0;
  logic [XLEN-1:0] acc_hi_p1;
  logic [XLEN-1:0] acc_lo_p1;
  logic [SHW-1:0]  cnt_p1;
  logic            last;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh;
  logic [XLEN+1:0]   div_diff;
  logic              div_ok;
  logic [XLEN-1:0]   step_hi;
  logic [XLEN-1:0]   step_lo;
  logic [2*XLEN-1:0] prod_c;
  logic [XLEN-1:0]   fin_res;

  assign last = (state == CALC) && (cnt_p1 == SHW'(XLEN - 1));

  always_comb begin
    // Shift-add: add the multiplicand when the low multiplier bit is set,
    // then shift the {carry, hi, lo} product right by one.
    mul_sum  = {1'b0, acc_hi_p1} + (acc_lo_p1[0] ? {1'b0, mag_b_p0} : '0);
    // Restoring division: the dividend shifts out of acc_lo into acc_hi,
    // quotient bits shift into acc_lo from the right.
    div_sh   = {acc_hi_p1, acc_lo_p1[XLEN-1]};
    div_diff = {1'b0, div_sh} - {2'b00, mag_b_p0};
    div_ok   = !div_diff[XLEN+1];
    if (fn_p0[2]) begin
      step_hi = div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
      step_lo = {acc_lo_p1[XLEN-2:0], div_ok};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], acc_lo_p1[XLEN-1:1]};
    end
    prod_c = fix_sign_wide(neg_q_p0, {step_hi, step_lo});
    case (fn_p0)
      3'b000:          fin_res = prod_c[XLEN-1:0];
      3'b100, 3'b101:  fin_res = fix_sign(neg_q_p0, step_lo);
      3'b110, 3'b111:  fin_res = fix_sign(neg_r_p0, step_hi);
      default:         fin_res = prod_c[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && go_calc) begin
      fn_p0     <= fn;
      neg_q_p0  <= neg_a ^ neg_b;
      neg_r_p0  <= neg_a;
      mag_b_p0  <= mag_b;
      acc_hi_p1 <= '0;
      acc_lo_p1 <= mag_a;
      cnt_p1    <= '0;
    end else if (state == CALC) begin
      acc_hi_p1 <= step_hi;
      acc_lo_p1 <= step_lo;
      cnt_p1    <= cnt_p1 + 1'b1;
    end
  end

  // Control: state register and next-state logic
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = go_calc ? CALC : DONE;
      CALC:    if (last) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE);

  // Output stage: result and flags written on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      zero   <= 1'b0;
      err    <= 1'b0;
    end else if (accept && !go_calc) begin
      result <= imm_res;
      zero   <= (imm_res == '0);
      err    <= imm_err;
    end else if (last) begin
      result <= fin_res;
      zero   <= (fin_res == '0);
      err    <= 1'b0;
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor of the core ALU: same RV32I base op set, plus a multi-cycle RV32M unit (shift-add multiplier, restoring divider).
- Sits between decode/issue and writeback.
- Registers every result with a Zero flag derived from the final result.
- Accepts one operation at a time. Holds its result until writeback consumes it.

Parameters:
- XLEN, 32, operand/result width; power of two, ≥8.
- EN_M, 1, 1 = M ops implemented; 0 = any op[4]=1 is illegal.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept (IDLE only)
- op  in  5  op[4]=M select; op[3:0] base code, or op[2:0]=funct3 when op[4]=1
- src_a  in  XLEN  operand A
- src_b  in  XLEN  operand B
- out_valid  out  1  result/zero/err valid
- out_ready  in  1  consumer takes result
- result  out  XLEN  registered result
- zero  out  1  result==0
- err  out  1  illegal op code

Behaviour:
- Reset (sync, clk edge with reset=1):
  - state=IDLE; out_valid=0, result=0, zero=0, err=0; in_ready=1 the cycle after.
  - Overrides everything, including mid-CALC (aborts the op, no result emitted) and DONE (result discarded).
- States: IDLE, CALC, DONE.
  - in_ready = (state==IDLE) and not reset.
  - out_valid = (state==DONE).
- Accept: in_valid & in_ready at edge T latches op, src_a, src_b.
- Base ops (op[4]=0), codes:
  - ADD 0000, SUB 1000.
  - SLL 0001, SRL 0101, SRA 1101: shift amount = src_b[log2(XLEN)-1:0]; SRA is a true arithmetic right shift.
  - SLT 0010 signed compare; SLTU 0011 unsigned compare.
  - XOR 0100, OR 0110, AND 0111.
  - Result written at T; DONE from T+1 (1-cycle latency).
- Illegal codes: any other base code, or op[4]=1 with EN_M=0.
  - result=0, err=1, zero=1, DONE at T+1.
- M ops (op[4]=1, EN_M=1), selected by op[2:0]:
  - MUL 000 (low XLEN bits), MULH 001 (s×s high), MULHSU 010 (s×u high), MULHU 011 (u×u high).
  - DIV 100, DIVU 101, REM 110, REMU 111.
- Iterative path:
  - Operands are converted to magnitudes; signs recorded per op type.
  - CALC runs exactly XLEN cycles, one bit per cycle.
  - Sign correction is applied on the last CALC edge.
  - out_valid is first high at T+XLEN+1.
- Division special cases (detected at accept, no CALC, DONE at T+1):
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → src_a.
  - Signed overflow, DIV/REM with src_a = −2^(XLEN−1) and src_b = −1: DIV → src_a; REM → 0.
- Remainder sign follows the dividend; quotient truncates toward zero.
- zero, err:
  - Computed from the final result value in the same edge as result (never from a stale value).
  - err=0 for all legal ops.
- DONE:
  - result/zero/err stable while out_ready=0.
  - out_valid & out_ready at edge → IDLE next cycle, out_valid=0.
  - in_valid is ignored outside IDLE: no queuing, inputs may change freely.
- Throughput: base op 1 per 2 cycles with out_ready tied high; M op 1 per XLEN+2.
- All arithmetic is modulo 2^XLEN. Inputs are sampled only at accept, so operand changes during CALC have no effect.

Test Plan:
- Base sweep, XLEN=32:
  - ADD 7+(−7) → result 0, zero=1, latency 1.
  - SUB 5−9 → 0xFFFFFFFC.
  - SRA 0x80000000>>4 → 0xF8000000.
  - SLL by src_b=0x21 → shift 1.
  - SLT(−1,1) → 1; SLTU(0xFFFFFFFF,1) → 0.
- Multiply:
  - MUL 0xFFFFFFFF×0xFFFFFFFF → 1.
  - MULHU same → 0xFFFFFFFE; MULH same → 0; MULHSU(−1,2) → 0xFFFFFFFF.
  - out_valid first at T+33.
- Divide:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
  - Special cases: DIV x/0 → 0xFFFFFFFF at T+1; REMU 13/0 → 13; DIV 0x80000000/−1 → 0x80000000, REM → 0.
- Handshake:
  - Hold out_ready=0 for 5 cycles in DONE → result stable, in_ready=0, extra in_valid pulses ignored.
  - Assert out_ready → in_ready=1 next cycle; then a back-to-back ADD accepted.
- Reset mid-op:
  - Assert reset at CALC cycle 10 of a DIVU → next cycle IDLE, out_valid=0, result=0.
  - A fresh ADD 1+1 then completes → 2.
- Illegal/param:
  - op=5'b01001 → err=1, result=0, zero=1.
  - EN_M=0 with MUL → err=1 at T+1.
  - XLEN=16 build: MULHU 0xFFFF×0xFFFF → 0xFFFE, latency 17.
